uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter with a valid/ready byte interface and a built-in baud counter.

---
 rtl/uart_tx_frame.sv | 149 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word input, internal baud counter, optional
// parity, 1 or 2 stop bits, and zero-gap back-to-back frames.
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              tx,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int BIT_W = 5;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             PAR_SEED  = (PARITY_ODD != 0);

  if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
    $error("uart_tx_frame: DATA_W must be in 1..16");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    baud_reg, baud_next;
  logic [BIT_W-1:0]    bit_reg, bit_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                par_reg, par_next;
  logic                tx_reg, tx_next;
  logic                bit_end;
  logic                last_stop;
  logic                accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;

    bit_end    = (baud_reg == BAUD_LAST);
    last_stop  = (state_reg == STOP) && bit_end && (bit_reg == STOP_LAST);
    tx_ready_o = !rst && ((state_reg == IDLE) || last_stop);
    done_o     = !rst && last_stop;
    accept     = tx_valid_i && tx_ready_o;

    if (state_reg != IDLE) begin
      baud_next = bit_end ? '0 : baud_reg + 1'b1;
    end

    // tx_next always carries the line value of the bit period that starts next cycle
    case (state_reg)
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_next[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            state_next = IDLE;
            bit_next   = '0;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
          tx_next = 1'b1;
        end
      end
      default: begin
        tx_next = 1'b1;
      end
    endcase

    // Acceptance wins over the STOP->IDLE exit so frames stream with no gap
    if (accept) begin
      state_next = START;
      baud_next  = '0;
      bit_next   = '0;
      shift_next = tx_data_i;
      par_next   = (^tx_data_i) ^ PAR_SEED;
      tx_next    = 1'b0;
    end
  end

  assign tx     = tx_reg;
  assign busy_o = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: four instances covering no parity,
// even parity, odd parity and two stop bits, checked against a frame model.
module tb_uart_tx_frame;

  localparam int CPB  = 4;
  localparam int NDUT = 4;
  localparam int PEN   [NDUT] = '{0, 1, 1, 0};
  localparam int PODD  [NDUT] = '{0, 0, 1, 0};
  localparam int NSTOP [NDUT] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       valid  [NDUT];
  logic [7:0] data   [NDUT];
  logic       ready  [NDUT];
  logic       tx_w   [NDUT];
  logic       busy   [NDUT];
  logic       done   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    uart_tx_frame #(
      .DATA_W      (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PEN[gi]),
      .PARITY_ODD  (PODD[gi]),
      .STOP_BITS   (NSTOP[gi])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_valid_i(valid[gi]),
      .tx_data_i (data[gi]),
      .tx_ready_o(ready[gi]),
      .tx        (tx_w[gi]),
      .busy_o    (busy[gi]),
      .done_o    (done[gi])
    );
  end

  task automatic check(input string name, input int d, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is a list of bit periods, start low, data LSB first,
  // optional parity making the count of ones even/odd, then stop bits high.
  function automatic int frame_bits(input int d);
    return 1 + 8 + PEN[d] + NSTOP[d];
  endfunction

  function automatic logic [15:0] frame_pattern(input int d, input logic [7:0] w);
    logic [15:0] p;
    int ones;
    ones = $countones(w);
    p    = '1;
    p[0] = 1'b0;
    for (int i = 0; i < 8; i++) p[1 + i] = w[i];
    if (PEN[d] != 0) p[9] = ((ones % 2) != PODD[d]);
    return p;
  endfunction

  task automatic run_frames(input int d, input logic [7:0] w0, input logic [7:0] w1,
                            input int nfr, input bit poke,
                            output int first_done, output logic par_seen, output int ndone);
    int          len;
    logic [15:0] pat;
    logic [7:0]  w;
    first_done = -1;
    par_seen   = 1'bx;
    ndone      = 0;
    @(negedge clk);
    check("ready_idle", d, 0, 32'(ready[d]), 32'd1);
    valid[d] = 1'b1;
    data[d]  = w0;
    len = frame_bits(d) * CPB;
    for (int f = 0; f < nfr; f++) begin
      w   = (f == 0) ? w0 : w1;
      pat = frame_pattern(d, w);
      for (int c = 1; c <= len; c++) begin
        @(negedge clk);
        if (c == 1) begin
          if (f == nfr - 1) valid[d] = 1'b0;
          else data[d] = w1;
        end
        if (poke) begin
          if (c >= 2 && c <= len - 2) begin
            valid[d] = c[0];
            data[d]  = 8'($urandom);
          end else if (c == len - 1) begin
            valid[d] = 1'b0;
          end
        end
        check("tx", d, f * len + c, 32'(tx_w[d]), 32'(pat[(c - 1) / CPB]));
        check("busy", d, f * len + c, 32'(busy[d]), 32'd1);
        check("done", d, f * len + c, 32'(done[d]), 32'(c == len));
        check("ready", d, f * len + c, 32'(ready[d]), 32'(c == len));
        if (done[d] === 1'b1) begin
          ndone++;
          if (first_done < 0) first_done = f * len + c;
        end
        if (PEN[d] != 0 && f == 0 && c == 9 * CPB + 2) par_seen = tx_w[d];
      end
    end
    @(negedge clk);
    check("idle_tx", d, nfr * len + 1, 32'(tx_w[d]), 32'd1);
    check("idle_busy", d, nfr * len + 1, 32'(busy[d]), 32'd0);
    check("idle_done", d, nfr * len + 1, 32'(done[d]), 32'd0);
    check("idle_ready", d, nfr * len + 1, 32'(ready[d]), 32'd1);
    $display("frame dut%0d data %02h/%02h frames %0d poke %0d first_done %0d done_pulses %0d",
             d, w0, w1, nfr, poke, first_done, ndone);
  endtask

  typedef struct {
    int         dut;
    logic [7:0] w0;
    logic [7:0] w1;
    int         nfr;
    bit         poke;
    int         exp_done;
    int         exp_ndone;
    logic       exp_par;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int   fd;
    int   nd;
    logic ps;
    int   d;
    logic [7:0] w;

    vecs[0] = '{0, 8'hA5, 8'h00, 1, 1'b0, 40, 1, 1'b0};
    vecs[1] = '{1, 8'h07, 8'h00, 1, 1'b0, 44, 1, 1'b1};
    vecs[2] = '{2, 8'h07, 8'h00, 1, 1'b0, 44, 1, 1'b0};
    vecs[3] = '{3, 8'hFF, 8'h00, 1, 1'b0, 44, 1, 1'b0};
    vecs[4] = '{0, 8'h55, 8'h0F, 2, 1'b0, 40, 2, 1'b0};
    vecs[5] = '{0, 8'h3C, 8'h00, 1, 1'b1, 40, 1, 1'b0};

    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check("rst_tx", i, 0, 32'(tx_w[i]), 32'd1);
      check("rst_busy", i, 0, 32'(busy[i]), 32'd0);
      check("rst_done", i, 0, 32'(done[i]), 32'd0);
      check("rst_ready", i, 0, 32'(ready[i]), 32'd0);
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_frames(vecs[i].dut, vecs[i].w0, vecs[i].w1, vecs[i].nfr, vecs[i].poke, fd, ps, nd);
      check("done_cycle", vecs[i].dut, fd, 32'(fd), 32'(vecs[i].exp_done));
      check("done_count", vecs[i].dut, fd, 32'(nd), 32'(vecs[i].exp_ndone));
      if (PEN[vecs[i].dut] != 0)
        check("parity_bit", vecs[i].dut, 9 * CPB + 2, 32'(ps), 32'(vecs[i].exp_par));
    end

    for (int k = 0; k < 12; k++) begin
      d = int'($urandom_range(0, NDUT - 1));
      w = 8'($urandom);
      run_frames(d, w, 8'h00, 1, 1'b0, fd, ps, nd);
      check("rand_done_cycle", d, fd, 32'(fd), 32'(frame_bits(d) * CPB));
      check("rand_done_count", d, fd, 32'(nd), 32'd1);
    end

    // Reset in the middle of data bit 3 abandons the frame
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_tx_bit3", 0, 18, 32'(tx_w[0]), 32'd0);
    check("mid_busy", 0, 18, 32'(busy[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", 0, 19, 32'(tx_w[0]), 32'd1);
    check("abort_busy", 0, 19, 32'(busy[0]), 32'd0);
    check("abort_done", 0, 19, 32'(done[0]), 32'd0);
    check("abort_ready", 0, 19, 32'(ready[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 0, 20, 32'(ready[0]), 32'd1);
    check("post_rst_tx", 0, 20, 32'(tx_w[0]), 32'd1);
    $display("reset abort dut0 data a5 at data bit 3");
    run_frames(0, 8'hC3, 8'h00, 1, 1'b0, fd, ps, nd);
    check("post_rst_done_cycle", 0, fd, 32'(fd), 32'd40);
    check("post_rst_done_count", 0, fd, 32'(nd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
